// File: rtl/idt_row_writer.sv
// Producer side of the instruction dependency table: allocates slots, builds dependency rows,
// and clears completed columns with a skip-ahead sweep. Optional WAW ordering: IDT_WAW_DEP_EN.

module idt_dep_match #(
    parameter int rw  = 5,
    parameter bit waw = 1'b0
) (
    input  logic          busy,
    input  logic [rw-1:0] rd,
    input  logic [rw-1:0] in_rd,
    input  logic [rw-1:0] in_rs1,
    input  logic [rw-1:0] in_rs2,
    output logic          dep
);
    logic raw_hit, waw_hit;

    // Register 0 is hardwired, so it never orders anything.
    assign raw_hit = (in_rs1 != '0 && rd == in_rs1) || (in_rs2 != '0 && rd == in_rs2);
    assign waw_hit = waw && in_rd != '0 && rd == in_rd;
    assign dep     = busy && (raw_hit || waw_hit);
endmodule

module idt_row_writer #(
    parameter int bs = 16,
    parameter int rw = 5,
    localparam int bs_bits = $clog2(bs)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [rw-1:0]      in_rd,
    input  logic [rw-1:0]      in_rs1,
    input  logic [rw-1:0]      in_rs2,
    input  logic               iss_valid,
    input  logic [bs_bits-1:0] iss_index,
    output logic               iss_ready,
    input  logic               done_valid,
    input  logic [bs_bits-1:0] done_index,
    output logic               done_ready,
    output logic               wr_en,
    output logic [bs_bits-1:0] wr_index,
    output logic [bs-1:0]      wr_row,
    output logic               full,
    output logic [bs_bits-1:0] alloc_index
);
`ifdef IDT_WAW_DEP_EN
    localparam bit waw_en = 1'b1;
`else
    localparam bit waw_en = 1'b0;
`endif

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                   state, state_nxt;
    logic [bs-1:0]            busy, busy_nxt, issued;
    logic [bs-1:0][rw-1:0]    rd_q;
    logic [bs-1:0][bs-1:0]    shadow;
    logic [bs_bits-1:0]       col_q;
    logic [bs_bits:0]         ptr_q;

    logic [bs-1:0]            dep_row;
    logic [bs_bits-1:0]       free_idx;
    logic                     sweep_hit;
    logic [bs_bits-1:0]       sweep_idx;
    logic [bs-1:0]            sweep_row;
    logic                     done_fire, iss_fire, alloc_fire;

    assign done_fire  = done_valid && done_ready;
    assign iss_fire   = iss_valid && iss_ready;
    assign alloc_fire = in_valid && in_ready;

    for (genvar j = 0; j < bs; j++) begin : g_dep
        idt_dep_match #(.rw(rw), .waw(waw_en)) u_dep (
            .busy   (busy[j]),
            .rd     (rd_q[j]),
            .in_rd  (in_rd),
            .in_rs1 (in_rs1),
            .in_rs2 (in_rs2),
            .dep    (dep_row[j])
        );
    end

    always_comb begin
        free_idx = '0;
        for (int r = bs - 1; r >= 0; r--)
            if (!busy[r]) free_idx = bs_bits'(r);
    end

    // Skip-ahead: lowest row at or past the pointer that still waits on the completed column.
    always_comb begin
        sweep_hit = 1'b0;
        sweep_idx = '0;
        for (int r = bs - 1; r >= 0; r--)
            if (busy[r] && !issued[r] && shadow[r][col_q] && (bs_bits + 1)'(r) >= ptr_q) begin
                sweep_hit = 1'b1;
                sweep_idx = bs_bits'(r);
            end
    end

    always_comb begin
        sweep_row        = shadow[sweep_idx];
        sweep_row[col_q] = 1'b0;
    end

    always_comb begin
        busy_nxt = busy;
        if (state == IDLE) begin
            if (done_fire)       busy_nxt[done_index] = 1'b0;
            else if (alloc_fire) busy_nxt[free_idx]   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (done_fire && busy[done_index]) state_nxt = SWEEP;
            SWEEP:   if (!sweep_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done_ready = (state == IDLE);
        iss_ready  = (state == IDLE) && !done_valid;
        in_ready   = (state == IDLE) && !done_valid && !iss_valid && !full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            issued      <= '0;
            rd_q        <= '0;
            shadow      <= '1;
            wr_en       <= 1'b0;
            wr_index    <= '0;
            wr_row      <= '1;
            alloc_index <= '0;
            full        <= 1'b0;
            col_q       <= '0;
            ptr_q       <= '0;
        end else begin
            busy  <= busy_nxt;
            full  <= &busy_nxt;
            wr_en <= 1'b0;
            if (state == IDLE) begin
                if (done_fire) begin
                    if (busy[done_index]) begin
                        issued[done_index] <= 1'b0;
                        shadow[done_index] <= '1;
                        wr_en              <= 1'b1;
                        wr_index           <= done_index;
                        wr_row             <= '1;
                        col_q              <= done_index;
                        ptr_q              <= '0;
                    end
                end else if (iss_fire) begin
                    // All-ones keeps the IDT from ever reporting an issued slot ready again.
                    if (busy[iss_index]) begin
                        issued[iss_index] <= 1'b1;
                        shadow[iss_index] <= '1;
                        wr_en             <= 1'b1;
                        wr_index          <= iss_index;
                        wr_row            <= '1;
                    end
                end else if (alloc_fire) begin
                    rd_q[free_idx]   <= in_rd;
                    shadow[free_idx] <= dep_row;
                    wr_en            <= 1'b1;
                    wr_index         <= free_idx;
                    wr_row           <= dep_row;
                    alloc_index      <= free_idx;
                end
            end else if (sweep_hit) begin
                shadow[sweep_idx] <= sweep_row;
                wr_en             <= 1'b1;
                wr_index          <= sweep_idx;
                wr_row            <= sweep_row;
                ptr_q             <= {1'b0, sweep_idx} + (bs_bits + 1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_idt_row_writer.sv
// Scoreboard bench for idt_row_writer: a slot/row model predicts IDT writes and handshakes.

module tb_idt_row_writer;
    localparam int BS = 16;
    localparam int RW = 5;

    logic          clk, rst;
    logic          in_valid, in_ready;
    logic [RW-1:0] in_rd, in_rs1, in_rs2;
    logic          iss_valid, iss_ready;
    logic [3:0]    iss_index;
    logic          done_valid, done_ready;
    logic [3:0]    done_index;
    logic          wr_en;
    logic [3:0]    wr_index;
    logic [BS-1:0] wr_row;
    logic          full;
    logic [3:0]    alloc_index;

    idt_row_writer #(.bs(BS), .rw(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .iss_valid(iss_valid), .iss_index(iss_index), .iss_ready(iss_ready),
        .done_valid(done_valid), .done_index(done_index), .done_ready(done_ready),
        .wr_en(wr_en), .wr_index(wr_index), .wr_row(wr_row),
        .full(full), .alloc_index(alloc_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [BS-1:0] row;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Model: which slots hold live instructions and what each one still waits on.
    bit            m_busy[BS];
    bit            m_iss[BS];
    logic [RW-1:0] m_rd[BS];
    logic [BS-1:0] m_row[BS];
    int            m_alloc;
    int            sweep_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got idx %0d row %h, expected no write (t=%0t)",
                         wr_index, wr_row, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_index", 32'(wr_index), 32'(e.idx));
                chk("wr_row", 32'(wr_row), 32'(e.row));
            end
        end
    end

    function automatic bit m_full();
        int n = 0;
        for (int i = 0; i < BS; i++) n += int'(m_busy[i]);
        return n == BS;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BS; i++) begin
            m_busy[i] = 0;
            m_iss[i]  = 0;
            m_rd[i]   = '0;
            m_row[i]  = '1;
        end
        m_alloc    = 0;
        sweep_left = 0;
    endtask

    task automatic model_alloc(input logic [RW-1:0] rd_i, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
        int            s = -1;
        logic [BS-1:0] row = '0;
        for (int i = BS - 1; i >= 0; i--) if (!m_busy[i]) s = i;
        for (int j = 0; j < BS; j++) begin
            bit d = m_busy[j] && ((r1 != 0 && m_rd[j] == r1) || (r2 != 0 && m_rd[j] == r2));
`ifdef IDT_WAW_DEP_EN
            d = d || (m_busy[j] && rd_i != 0 && m_rd[j] == rd_i);
`endif
            row[j] = d;
        end
        m_busy[s] = 1;
        m_rd[s]   = rd_i;
        m_row[s]  = row;
        m_alloc   = s;
        exp_q.push_back('{s, row});
    endtask

    task automatic model_issue(input int i);
        if (m_busy[i]) begin
            m_iss[i] = 1;
            m_row[i] = '1;
            exp_q.push_back('{i, '1});
        end
    endtask

    task automatic model_done(input int k);
        int n = 0;
        if (!m_busy[k]) return;
        m_busy[k] = 0;
        m_iss[k]  = 0;
        m_row[k]  = '1;
        exp_q.push_back('{k, '1});
        for (int r = 0; r < BS; r++)
            if (m_busy[r] && !m_iss[r] && m_row[r][k]) begin
                m_row[r][k] = 1'b0;
                exp_q.push_back('{r, m_row[r]});
                n++;
            end
        sweep_left = n + 1;
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic cycle(input bit iv, input logic [RW-1:0] rd_i, input logic [RW-1:0] r1,
                         input logic [RW-1:0] r2, input bit sv, input logic [3:0] si,
                         input bit dv, input logic [3:0] di);
        in_valid = iv; in_rd = rd_i; in_rs1 = r1; in_rs2 = r2;
        iss_valid = sv; iss_index = si; done_valid = dv; done_index = di;
        @(negedge clk);
        chk("full", 32'(full), 32'(m_full()));
        chk("alloc_index", 32'(alloc_index), 32'(m_alloc));
        if (sweep_left > 0) begin
            chk("done_ready_sweep", 32'(done_ready), 0);
            chk("iss_ready_sweep", 32'(iss_ready), 0);
            chk("in_ready_sweep", 32'(in_ready), 0);
            #1;
            sweep_left--;
        end else begin
            chk("done_ready", 32'(done_ready), 1);
            chk("iss_ready", 32'(iss_ready), 32'(!dv));
            chk("in_ready", 32'(in_ready), 32'(!dv && !sv && !m_full()));
            #1;
            if (dv)                      model_done(int'(di));
            else if (sv)                 model_issue(int'(si));
            else if (iv && !m_full())    model_alloc(rd_i, r1, r2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 0, '0, 0, '0);
    endtask

    task automatic do_reset();
        in_valid = 0; iss_valid = 0; done_valid = 0; rst = 1;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_reset();
        rst = 0;
        @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_index", 32'(wr_index), 0);
        chk("rst_wr_row", 32'(wr_row), 32'hFFFF);
        chk("rst_alloc_index", 32'(alloc_index), 0);
        chk("rst_full", 32'(full), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [RW-1:0] rd_i, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
        cycle(1, rd_i, r1, r2, 0, '0, 0, '0);
    endtask

    initial begin
        rst = 1; in_valid = 0; iss_valid = 0; done_valid = 0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; iss_index = '0; done_index = '0;
        model_reset();
        do_reset();

        // Dependency chain, issue, completion sweep.
        alloc(5'd1, 5'd2, 5'd3);
        alloc(5'd4, 5'd1, 5'd0);
        alloc(5'd5, 5'd1, 5'd4);
        cycle(0, '0, '0, '0, 1, 4'd0, 0, '0);
        cycle(0, '0, '0, '0, 0, '0, 1, 4'd0);
        idle(4);

        // All three offered together: completion wins, then issue, then alloc.
        cycle(1, 5'd6, 5'd5, 5'd0, 1, 4'd1, 1, 4'd2);
        cycle(1, 5'd6, 5'd5, 5'd0, 1, 4'd1, 0, '0);
        cycle(1, 5'd6, 5'd5, 5'd0, 1, 4'd1, 0, '0);
        cycle(1, 5'd6, 5'd5, 5'd0, 0, '0, 0, '0);
        idle(2);

        // Fill every slot, hold the 17th, free slot 7 and reuse it.
        do_reset();
        for (int i = 0; i < BS; i++) alloc(5'(i + 8), 5'd0, 5'd0);
        alloc(5'd3, 5'd1, 5'd2);
        alloc(5'd3, 5'd1, 5'd2);
        cycle(0, '0, '0, '0, 0, '0, 1, 4'd7);
        idle(2);
        alloc(5'd3, 5'd15, 5'd0);
        idle(2);

        // Reset lands in the middle of a sweep.
        do_reset();
        alloc(5'd1, 5'd2, 5'd3);
        alloc(5'd4, 5'd1, 5'd0);
        alloc(5'd5, 5'd1, 5'd4);
        cycle(0, '0, '0, '0, 0, '0, 1, 4'd0);
        idle(1);
        do_reset();
        alloc(5'd1, 5'd2, 5'd3);
        alloc(5'd1, 5'd0, 5'd0);
        idle(2);

        // Random traffic over a small register range so dependencies are common.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            else cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)));
        end

        idle(BS + 4);
        chk("pending_writes", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
